// File: rtl/dbuf_sched_if.sv
// Pixel-strobe / frame-memory / filter-engine signal bundle for the ping-pong scheduler.
// master drives the pixel strobe and engine completion; slave is the scheduler.
interface dbuf_sched_if #(
  parameter int unsigned AW = 16
);
  logic          i_strb;
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic          op_start;
  logic          op_bank;
  logic          op_done;
  logic [1:0]    bank_full;
  logic          busy;
  logic          ovf;

  modport master (
    output i_strb,
    output op_done,
    input  wr_en,
    input  wr_bank,
    input  wr_addr,
    input  op_start,
    input  op_bank,
    input  bank_full,
    input  busy,
    input  ovf
  );

  modport slave (
    input  i_strb,
    input  op_done,
    output wr_en,
    output wr_bank,
    output wr_addr,
    output op_start,
    output op_bank,
    output bank_full,
    output busy,
    output ovf
  );
endinterface

// File: rtl/dbuf_sched.sv
// Ping-pong scheduler: fills one frame bank from the pixel stream while the filter
// engine reads the other, handing banks over strictly in fill order.
module dbuf_sched #(
  parameter int unsigned PIX_CNT = 65536,
  parameter int unsigned AW      = 16
) (
  input logic         clk,
  input logic         reset,
  dbuf_sched_if.slave bus
);

  typedef enum logic [1:0] {RIdle, RStart, RRun} rstate_e;

  localparam logic [AW-1:0] LastAddr = AW'(PIX_CNT - 1);

  rstate_e       state_q, state_d;
  logic [1:0]    bank_full_q, bank_full_d;
  logic          wb_q, wb_d;
  logic          rb_q, rb_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wcnt_q, wcnt_d;

  logic accept;
  logic drop;
  logic last_pix;
  logic rd_release;

  assign accept   = bus.i_strb & ~bank_full_q[wb_q];
  assign drop     = bus.i_strb & bank_full_q[wb_q];
  assign last_pix = (wcnt_q == LastAddr);

  // Writer: advance address, flip to the other bank after the last pixel of a frame.
  always_comb begin
    wb_d   = wb_q;
    wcnt_d = wcnt_q;
    ovf_d  = ovf_q | drop;
    if (accept) begin
      if (last_pix) begin
        wcnt_d = '0;
        wb_d   = ~wb_q;
      end else begin
        wcnt_d = wcnt_q + AW'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rb_d       = rb_q;
    rd_release = 1'b0;
    unique case (state_q)
      RIdle: begin
        if (bank_full_q[rb_q]) state_d = RStart;
      end
      RStart: begin
        state_d = RRun;
      end
      RRun: begin
        if (bus.op_done) begin
          rd_release = 1'b1;
          rb_d       = ~rb_q;
          state_d    = RIdle;
        end
      end
      default: state_d = RIdle;
    endcase
  end

  // Writer only sets an empty bank and the reader only clears a full one, so a
  // set and a clear in the same cycle always target different bits.
  always_comb begin
    bank_full_d = bank_full_q;
    if (rd_release) bank_full_d[rb_q] = 1'b0;
    if (accept && last_pix) bank_full_d[wb_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RIdle;
      bank_full_q <= 2'b00;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      ovf_q       <= 1'b0;
      wcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      bank_full_q <= bank_full_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      ovf_q       <= ovf_d;
      wcnt_q      <= wcnt_d;
    end
  end

  assign bus.wr_en     = accept;
  assign bus.wr_bank   = wb_q;
  assign bus.wr_addr   = wcnt_q;
  assign bus.op_start  = (state_q == RStart);
  assign bus.op_bank   = rb_q;
  assign bus.bank_full = bank_full_q;
  assign bus.busy      = (state_q != RIdle);
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_dbuf_sched.sv
// Bench for dbuf_sched: directed scenarios plus random strobe/done traffic, checked
// against a timestamp-based reference model of frame fill and engine hand-over.
module tb_dbuf_sched;

  localparam int unsigned PIX = 16;
  localparam int unsigned AW  = 4;

  logic clk;
  logic reset;

  dbuf_sched_if #(.AW(AW)) bus ();

  dbuf_sched #(
    .PIX_CNT(PIX),
    .AW     (AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     total;
  int     passed;
  int     failed;
  longint cyc;

  // Reference model: fill position, which banks hold complete frames, which bank
  // the engine owns next, and the cycle in which its start pulse is due.
  int     m_wb;
  int     m_wcnt;
  int     m_rb;
  bit     m_full [2];
  bit     m_ovf;
  longint m_start;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_wb      = 0;
    m_wcnt    = 0;
    m_rb      = 0;
    m_full[0] = 1'b0;
    m_full[1] = 1'b0;
    m_ovf     = 1'b0;
    m_start   = -1;
  endfunction

  // One clock cycle: drive inputs, check mid-cycle, then advance the model.
  task automatic step(input bit strb, input bit done);
    bit acc;
    bus.i_strb  = strb;
    bus.op_done = done;
    #4;
    acc = strb && !m_full[m_wb];
    chk("wr_en",     32'(bus.wr_en),     32'(acc));
    chk("wr_bank",   32'(bus.wr_bank),   32'(m_wb));
    chk("wr_addr",   32'(bus.wr_addr),   32'(m_wcnt));
    chk("op_start",  32'(bus.op_start),  32'(cyc == m_start));
    chk("busy",      32'(bus.busy),      32'(m_start >= 0 && cyc >= m_start));
    chk("op_bank",   32'(bus.op_bank),   32'(m_rb));
    chk("bank_full", 32'(bus.bank_full), {30'd0, m_full[1], m_full[0]});
    chk("ovf",       32'(bus.ovf),       32'(m_ovf));

    if (strb && !acc) m_ovf = 1'b1;
    // The engine is running only from the cycle after its start pulse.
    if (done && m_start >= 0 && cyc > m_start) begin
      m_full[m_rb] = 1'b0;
      m_rb         = m_rb ^ 1;
      m_start      = -1;
    end
    if (acc) begin
      if (m_wcnt == int'(PIX) - 1) begin
        m_full[m_wb] = 1'b1;
        m_wb         = m_wb ^ 1;
        m_wcnt       = 0;
      end else begin
        m_wcnt++;
      end
    end
    // A full bank visible to an idle reader next cycle is started the cycle after.
    if (m_start < 0 && m_full[m_rb]) m_start = cyc + 2;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asynchronous reset mid-cycle; outputs must drop to reset values at once.
  task automatic do_reset();
    bus.i_strb  = 1'b1;
    bus.op_done = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_wr_en",     32'(bus.wr_en),     32'd1);
    chk("rst_wr_bank",   32'(bus.wr_bank),   32'd0);
    chk("rst_wr_addr",   32'(bus.wr_addr),   32'd0);
    chk("rst_op_start",  32'(bus.op_start),  32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_op_bank",   32'(bus.op_bank),   32'd0);
    chk("rst_bank_full", 32'(bus.bank_full), 32'd0);
    chk("rst_ovf",       32'(bus.ovf),       32'd0);
    bus.i_strb = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    cyc++;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    total       = 0;
    passed      = 0;
    failed      = 0;
    cyc         = 0;
    reset       = 1'b0;
    bus.i_strb  = 1'b0;
    bus.op_done = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Single frame into bank 0, then completion.
    do_reset();
    strobes(16);
    idles(3);
    step(1'b0, 1'b1);
    idles(2);

    // Back-to-back frames with completion withheld, then drain both banks.
    do_reset();
    strobes(32);
    idles(4);
    step(1'b0, 1'b1);
    idles(4);
    step(1'b0, 1'b1);
    idles(3);

    // Overflow: eight dropped pixels, then a freed bank restarts at address 0.
    do_reset();
    strobes(40);
    idles(2);
    step(1'b0, 1'b1);
    strobes(2);
    idles(2);

    // Completion of bank 0 coincides with the last pixel of bank 1.
    do_reset();
    strobes(16);
    strobes(15);
    step(1'b1, 1'b1);
    idles(4);

    // Reset during a partial frame with the engine running; stray done afterwards.
    do_reset();
    strobes(16);
    strobes(7);
    idles(2);
    do_reset();
    step(1'b0, 1'b1);
    idles(2);
    strobes(16);
    idles(3);
    step(1'b0, 1'b1);
    idles(1);

    // Random traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        step(bit'($urandom_range(0, 9) < 7), bit'($urandom_range(0, 4) == 0));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dbuf_sched.md
# dbuf_sched

Ping-pong scheduler for the Filter2D double-buffered frame store. Sits between the pixel input stream and the two-bank frame memory/`filter2d_op` pair: steers incoming pixels into the bank being filled, and hands each completed bank to the filter engine with a one-cycle start pulse. It frees a bank when the engine reports completion. Pixels arriving while both banks are occupied are dropped and flagged.

## Interface
- `PIX_CNT`, default 65536: pixels per frame (256x256); must be ≥2.
- `AW`, default 16: address width; 2^AW ≥ PIX_CNT.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `i_strb` in 1: input pixel valid (pixel data bypasses this block).
- `wr_en` out 1: write strobe to frame memory (combinational).
- `wr_bank` out 1: bank receiving writes.
- `wr_addr` out AW: write address within bank.
- `op_start` out 1: one-cycle start pulse to filter engine.
- `op_bank` out 1: bank the engine reads; stable from `op_start` until `op_done`.
- `op_done` in 1: one-cycle pulse from engine, frame finished.
- `bank_full` out 2: per-bank occupied flag (full or being read).
- `busy` out 1: engine running (reader in R_RUN or R_START).
- `ovf` out 1: sticky; set when a pixel is dropped; cleared only by reset.

## Operation
- Registered state: `bank_full[1:0]`, writer bank `wb`, write counter `wcnt` (AW bits), reader bank `rb`, reader FSM, `ovf`.
- Writer: `wr_en = i_strb & ~bank_full[wb]`; `wr_bank = wb`; `wr_addr = wcnt`.
  - On accepted write with `wcnt != PIX_CNT-1`: `wcnt++`.
  - On accepted write with `wcnt == PIX_CNT-1`: `wcnt <= 0`, `bank_full[wb] <= 1`, `wb <= ~wb`.
  - `i_strb` while `bank_full[wb]` = 1: pixel dropped, `wr_en` = 0, `ovf <= 1`; `wcnt` and `wb` unchanged.
- Reader FSM, states R_IDLE, R_START, R_RUN:
  - R_IDLE: if `bank_full[rb]`, go to R_START; otherwise stay.
  - R_START: `op_start` = 1 (registered state output); next state R_RUN.
  - R_RUN: on `op_done`, `bank_full[rb] <= 0`, `rb <= ~rb`, next state R_IDLE.
  - `op_done` outside R_RUN is ignored.
- `op_bank = rb`. Banks are consumed strictly in fill order (0,1,0,1,…).
- Simultaneous set and clear of the same `bank_full` bit cannot occur. The writer sets bit `wb` only when it is 0; the reader clears bit `rb` only when it is 1 and in R_RUN.
- Set of one bank and clear of the other in the same cycle: both take effect.

## Timing
- Reset values: `wb`=0, `rb`=0, `wcnt`=0, `bank_full`=00, FSM=R_IDLE. Outputs: `op_start`=0, `busy`=0, `ovf`=0, `op_bank`=0, `wr_bank`=0, `wr_addr`=0. `wr_en` follows `i_strb` with bank 0 empty.
- Reset mid-frame: partial frame discarded; engine run abandoned (a later `op_done` is ignored).
- Write path: zero latency; `wr_en`/`wr_addr` are valid in the same cycle as `i_strb`.
- Last pixel accepted in cycle T: `bank_full` set in T+1; FSM in R_START in T+2, so `op_start` is high in T+2 only. This assumes the reader is idle on that bank.
- `op_done` in cycle D: `bank_full[rb]` cleared and `busy` = 0 in D+1. If the other bank is already full, `op_start` is high in D+2.
- Stalled writer: the freed bank accepts `i_strb` from D+1.
- Minimum turnaround between `op_start` pulses: 3 cycles.

## Test plan
- Use `PIX_CNT`=16 throughout.
- Single frame: 16 consecutive strobes from reset. Required: `wr_addr` 0..15 on bank 0, `op_start` 2 cycles after the 16th strobe with `op_bank`=0, `bank_full`=01. `op_done` then gives `bank_full`=00 and `busy`=0.
- Back-to-back frames: 32 consecutive strobes with `op_done` withheld. Required: second frame written to bank 1 at `wr_addr` 0..15, `bank_full`=11, no second `op_start`. `op_done` then gives bank 1 start 2 cycles later, `op_bank`=1.
- Overflow: 40 strobes with no `op_done`. Required: strobes 33..40 have `wr_en`=0 and `ovf`=1 from the cycle after strobe 33. After `op_done`, the next strobe writes bank 0, address 0.
- Simultaneous events: `op_done` for bank 0 in the same cycle as the last pixel of bank 1. Required: `bank_full`=10 next cycle, bank 1 `op_start` 2 cycles after `op_done`.
- Reset mid-operation: assert `reset` after 7 strobes and during R_RUN. Required: all outputs at reset values immediately (asynchronous), a stray `op_done` afterward is ignored, and the next frame starts at bank 0, address 0.
